// File: rtl/select_sequencer.sv
// select_sequencer: scans a 2-to-4 decoder select pair {s1,s0} across channels,
// holding each channel for dwell+1 cycles, with stop/step/resume control.
// Optional feature macro: SELECT_SEQ_SKIP_EN adds skip_mask[3:0] to drop channels
// from the scan; an all-ones mask disables the sequencer.
module select_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SELECT_SEQ_SKIP_EN
    input  logic [3:0]         skip_mask,
`endif
    output logic               s0,
    output logic               s1,
    output logic               valid,
    output logic               wrap,
    output logic               busy
);

    localparam int unsigned CH_W   = 2;
    localparam int unsigned N_CH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CH_W-1:0]    r_chan;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_valid;
    logic               r_wrap;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [CH_W-1:0]    w_chan_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_valid_nxt;
    logic               w_wrap_nxt;
    logic               w_busy_nxt;

    logic [N_CH-1:0]    w_mask;
    logic               w_all_skip;
    logic [CH_W-1:0]    w_first_chan;
    logic [CH_W-1:0]    w_adv_chan;
    logic               w_adv_wrap;

    // Lowest channel not masked off (0 when every channel is masked).
    function automatic logic [CH_W-1:0] first_en(input logic [N_CH-1:0] mask);
        logic [CH_W-1:0] res;
        logic [CH_W-1:0] cand;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) begin
            cand = CH_W'(k);
            if (!found && !mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Next enabled channel after cur in ascending wrap-around order.
    function automatic logic [CH_W-1:0] next_en(input logic [CH_W-1:0] cur,
                                                input logic [N_CH-1:0] mask);
        logic [CH_W-1:0] res;
        logic [CH_W-1:0] cand;
        logic            found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= int'(N_CH); k++) begin
            cand = CH_W'(int'(cur) + k);
            if (!found && !mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

`ifdef SELECT_SEQ_SKIP_EN
    assign w_mask = skip_mask;
`else
    assign w_mask = 4'b0000;
`endif

    assign w_all_skip   = &w_mask;
    assign w_first_chan = first_en(w_mask);
    assign w_adv_chan   = next_en(r_chan, w_mask);
    assign w_adv_wrap   = (w_adv_chan <= r_chan);

    // Next-state and next-output computation.
    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_wrap_nxt  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start && !w_all_skip) begin
                    w_state_nxt = ST_RUN;
                    w_chan_nxt  = w_first_chan;
                    w_cnt_nxt   = dwell;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_all_skip) begin
                    w_state_nxt = ST_IDLE;
                    w_chan_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DWELL_W'(1);
                end else begin
                    w_chan_nxt = w_adv_chan;
                    w_cnt_nxt  = dwell;
                    w_wrap_nxt = w_adv_wrap;
                end
            end
            ST_PAUSE: begin
                if (w_all_skip) begin
                    w_state_nxt = ST_IDLE;
                    w_chan_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end else if (step) begin
                    w_chan_nxt = w_adv_chan;
                    w_cnt_nxt  = dwell;
                    w_wrap_nxt = w_adv_wrap;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_chan_nxt  = '0;
                w_cnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and registered outputs; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_chan  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_chan  <= w_chan_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign s0    = r_chan[0];
    assign s1    = r_chan[1];
    assign valid = r_valid;
    assign wrap  = r_wrap;
    assign busy  = r_busy;

endmodule

// File: tb/tb_select_sequencer.sv
// Directed bench for select_sequencer: scan timing, dwell, stop/step/resume,
// priorities, reset, and (when SELECT_SEQ_SKIP_EN is defined) channel skipping.
module tb_select_sequencer;

    localparam int unsigned DWELL_W = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               step;
    logic [DWELL_W-1:0] dwell;
`ifdef SELECT_SEQ_SKIP_EN
    logic [3:0]         skip_mask;
`endif
    logic               s0;
    logic               s1;
    logic               valid;
    logic               wrap;
    logic               busy;

    int errors = 0;
    int checks = 0;

    select_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .dwell     (dwell),
`ifdef SELECT_SEQ_SKIP_EN
        .skip_mask (skip_mask),
`endif
        .s0        (s0),
        .s1        (s1),
        .valid     (valid),
        .wrap      (wrap),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {s1,s0,valid,wrap,busy} against the expected tuple.
    task automatic chk(input string tag, input int ch, input logic v,
                       input logic w, input logic b);
        logic [4:0] obs;
        logic [4:0] exp_v;
        obs   = {s1, s0, valid, wrap, busy};
        exp_v = {2'(ch), v, w, b};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed s1s0/valid/wrap/busy=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
        dwell = 8'd2;
`ifdef SELECT_SEQ_SKIP_EN
        skip_mask = 4'b0000;
`endif
        tick();
        tick();
        chk("reset_state", 0, 1'b0, 1'b0, 1'b0);

        // Start with dwell=2: each channel held 3 cycles, wrap on 3->0.
        rst   = 1'b0;
        start = 1'b1;
        tick();
        chk("load_ch0", 0, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            if (t == 2) dwell = 8'd0;   // mid-dwell change must not matter
            if (t == 3) dwell = 8'd2;
            tick();
            chk("dwell2_seq", (t / 3) % 4, 1'b1, (t == 12), 1'b1);
        end

        // dwell=0: channel changes every cycle, wrap every 4th.
        dwell = 8'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("dwell0_seq", (1 + k) % 4, 1'b1, (((1 + k) % 4) == 0), 1'b1);
        end

        // Reset wins over start; first edge after reset honours start.
        dwell = 8'd2;
        rst   = 1'b1;
        start = 1'b1;
        tick();
        chk("rst_over_start", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk("start_after_rst", 0, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("run_to_ch2", (t / 3) % 4, 1'b1, 1'b0, 1'b1);
        end

        // Stop on channel 2 with counter at 1, stay frozen.
        stop = 1'b1;
        tick();
        chk("stop_pause", 2, 1'b1, 1'b0, 1'b1);
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pause_frozen", 2, 1'b1, 1'b0, 1'b1);
        end

        // Step twice: 3 then 0 with wrap; then hold in pause.
        step = 1'b1;
        tick();
        chk("step_ch3", 3, 1'b1, 1'b0, 1'b1);
        tick();
        chk("step_ch0_wrap", 0, 1'b1, 1'b1, 1'b1);
        step = 1'b0;
        tick();
        chk("pause_after_step", 0, 1'b1, 1'b0, 1'b1);

        // Resume: counter was reloaded by the step, so ch0 held 3 cycles.
        start = 1'b1;
        tick();
        chk("resume", 0, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        chk("resume_hold1", 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("resume_hold2", 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("resume_adv", 1, 1'b1, 1'b0, 1'b1);

        // stop+start together in RUN -> PAUSE.
        stop  = 1'b1;
        start = 1'b1;
        tick();
        chk("stop_beats_start", 1, 1'b1, 1'b0, 1'b1);
        stop  = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pause2_frozen", 1, 1'b1, 1'b0, 1'b1);
        end

        // start+step together in PAUSE -> resume only; both ignored in RUN.
        start = 1'b1;
        step  = 1'b1;
        tick();
        chk("start_beats_step", 1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("run_ignores_ss1", 1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("run_ignores_ss2", 1, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        step  = 1'b0;
        tick();
        chk("run_adv_ch2", 2, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk("run_adv_ch3", 3, 1'b1, 1'b0, 1'b1);
        tick();
        chk("ch3_mid_dwell", 3, 1'b1, 1'b0, 1'b1);

        // Reset mid-dwell on channel 3.
        rst = 1'b1;
        tick();
        chk("rst_mid_dwell", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // stop/step ignored in IDLE.
        stop = 1'b1;
        step = 1'b1;
        tick();
        chk("idle_ignores", 0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        step = 1'b0;
        tick();
        chk("idle_stays", 0, 1'b0, 1'b0, 1'b0);

`ifdef SELECT_SEQ_SKIP_EN
        // All channels masked: start ignored.
        skip_mask = 4'b1111;
        start     = 1'b1;
        tick();
        chk("skip_all_no_start", 0, 1'b0, 1'b0, 1'b0);
        // Mask 0101, dwell=0: 1,3,1,3,1 with wrap on each 3->1.
        skip_mask = 4'b0101;
        dwell     = 8'd0;
        tick();
        chk("skip_load_ch1", 1, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        chk("skip_ch3", 3, 1'b1, 1'b0, 1'b1);
        tick();
        chk("skip_ch1_wrap", 1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("skip_ch3_b", 3, 1'b1, 1'b0, 1'b1);
        tick();
        chk("skip_ch1_wrap_b", 1, 1'b1, 1'b1, 1'b1);
        skip_mask = 4'b1111;
        tick();
        chk("skip_all_idle", 0, 1'b0, 1'b0, 1'b0);
        skip_mask = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/select_sequencer.md
SELECT_SEQUENCER -- requirements
Module: select_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, giving the width of the dwell count.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin scanning from IDLE, or resume from PAUSE.
REQ-005 SHALL have port stop, input, 1 bit: freeze scanning (RUN to PAUSE).
REQ-006 SHALL have port step, input, 1 bit: advance exactly one channel while in PAUSE.
REQ-007 SHALL have port dwell, input, DWELL_W bits: cycles per channel, minus 1.
REQ-008 SHALL have port s0, output, 1 bit: select LSB, driving the 2-to-4 decoder s0 input.
REQ-009 SHALL have port s1, output, 1 bit: select MSB, driving the 2-to-4 decoder s1 input.
REQ-010 SHALL have port valid, output, 1 bit: s1:s0 is an active channel that downstream may decode.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse when the channel wraps back to the lowest channel.
REQ-012 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-013 SHALL implement a state machine with states IDLE, RUN and PAUSE; all outputs SHALL be registered.
REQ-014 In IDLE: {s1,s0}=00, valid=0, wrap=0; start=1 SHALL move to RUN on the next edge, with channel = lowest enabled channel, valid=1, and the counter loaded from dwell.
REQ-015 In RUN, a nonzero counter SHALL decrement by 1 per cycle; at counter=0 the channel SHALL advance to the next enabled channel (3 wraps to 0) and the counter SHALL reload from dwell.
REQ-016 Each channel SHALL be held for exactly dwell+1 cycles in RUN; dwell=0 SHALL advance the channel every cycle.
REQ-017 dwell SHALL be sampled only at load/reload; mid-dwell changes SHALL NOT affect the current channel.
REQ-018 wrap SHALL be 1 for exactly the cycle in which the new channel index is not greater than the previous one; wrap SHALL be 0 on the initial load from IDLE.
REQ-019 stop=1 in RUN SHALL move to PAUSE with channel and counter frozen and valid kept at 1.
REQ-020 In PAUSE: start=1 SHALL resume RUN with the counter value unchanged; step=1 SHALL advance one channel, reload the counter, apply the wrap rule, and remain in PAUSE.
REQ-021 Priority SHALL be stop > start > step; stop and start asserted in the same cycle in RUN SHALL give PAUSE; start and step in the same cycle in PAUSE SHALL give resume only, with no advance.
REQ-022 stop and step SHALL be ignored in IDLE; start and step SHALL be ignored in RUN.
REQ-023 {s1,s0} SHALL change only on an edge where the channel advances, loads or resets, so that decoder inputs never glitch mid-dwell.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, {s1,s0}=00, valid=0, wrap=0, busy=0 and counter=0, overriding every other input, in any state and at any point mid-dwell.
REQ-025 The first edge with rst=0 SHALL honour start.

Configuration
REQ-026 With macro SELECT_SEQ_SKIP_EN defined, the block SHALL add input skip_mask[3:0]; channels whose bit is 1 SHALL be skipped in every load and advance, using ascending wrap-around order.
REQ-027 With SELECT_SEQ_SKIP_EN defined and skip_mask=1111, start SHALL be ignored; if the mask becomes 1111 during RUN or PAUSE, the block SHALL go to IDLE on the next edge.
REQ-028 Without SELECT_SEQ_SKIP_EN, port skip_mask SHALL be absent and all four channels SHALL be visited.

Verification
REQ-029 Reset, then start with dwell=2 -> channels 0,1,2,3,0 are each held 3 cycles; wrap pulses once, on the 3->0 edge; busy=1.
REQ-030 dwell=0 -> the channel changes every cycle 0,1,2,3,0,...; wrap fires every 4th cycle.
REQ-031 stop on channel 2 with the counter at 1, then step twice -> channels 3, then 0 with wrap=1; a later start resumes RUN with the counter reloaded.
REQ-032 stop and start asserted in the same cycle in RUN -> PAUSE; rst mid-dwell on channel 3 -> next cycle {s1,s0}=00, valid=0, busy=0.
REQ-033 With SELECT_SEQ_SKIP_EN, skip_mask=0101, dwell=0 -> sequence 1,3,1,3 with wrap on each 3->1; setting the mask to 1111 -> IDLE on the next edge.
